// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream FIFO write port.
// Grant is held per packet; over-long packets get a forced last and are drained.
module axis_pkt_arbiter #(
   parameter int DataWidth = 32,
   parameter int NumPorts  = 4,
   parameter int MaxBeats  = 1024
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NumPorts*DataWidth-1:0] s_data,
   input  logic [NumPorts-1:0]           s_valid,
   input  logic [NumPorts-1:0]           s_last,
   output logic [NumPorts-1:0]           s_ready,
   output logic [DataWidth-1:0]          writeData,
   output logic                          writeDataValid,
   input  logic                          writeDataReady,
   output logic                          writeDataLast,
   output logic                          grant_valid,
   output logic [$clog2(NumPorts)-1:0]   grant_idx,
   output logic                          trunc_err
);

   localparam int IdxWidth = $clog2(NumPorts);
   localparam int CntWidth = $clog2(MaxBeats + 1);

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      DRAIN
   } state_t;

   state_t                r_state;
   logic [IdxWidth-1:0]   r_grant;
   logic [IdxWidth-1:0]   r_last_grant;
   logic [CntWidth-1:0]   r_beat_cnt;

   logic [DataWidth-1:0]  w_data [NumPorts];
   logic                  w_any;
   logic [IdxWidth-1:0]   w_sel;
   logic                  w_gvalid;
   logic                  w_glast;
   logic                  w_at_max;
   logic                  w_xfer;

   for (genvar i = 0; i < NumPorts; i++) begin : g_unpack
      assign w_data[i] = s_data[i*DataWidth +: DataWidth];
   end

   assign w_gvalid = s_valid[r_grant];
   assign w_glast  = s_last[r_grant];
   assign w_at_max = (r_beat_cnt == CntWidth'(MaxBeats - 1));
   assign w_xfer   = w_gvalid & writeDataReady;

   // Rotating priority: first requester after the last port served.
   always_comb begin
      int j;
      w_any = 1'b0;
      w_sel = '0;
      for (int k = 1; k <= NumPorts; k++) begin
         j = (int'(r_last_grant) + k) % NumPorts;
         if (!w_any && s_valid[j]) begin
            w_any = 1'b1;
            w_sel = IdxWidth'(j);
         end
      end
   end

   always_comb begin
      s_ready        = '0;
      writeData      = w_data[r_grant];
      writeDataValid = 1'b0;
      writeDataLast  = 1'b0;
      trunc_err      = 1'b0;
      unique case (r_state)
         PASS: begin
            writeDataValid   = w_gvalid;
            s_ready[r_grant] = writeDataReady;
            writeDataLast    = w_glast | w_at_max;
            trunc_err        = w_xfer & w_at_max & ~w_glast;
         end
         DRAIN: begin
            s_ready[r_grant] = 1'b1;
         end
         default: ;
      endcase
   end

   assign grant_valid = (r_state != IDLE);
   assign grant_idx   = r_grant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= IdxWidth'(NumPorts - 1);
         r_beat_cnt   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant    <= w_sel;
                  r_beat_cnt <= '0;
                  r_state    <= PASS;
               end
            end
            PASS: begin
               if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + CntWidth'(1);
                  if (w_glast) begin
                     r_last_grant <= r_grant;
                     r_state      <= IDLE;
                  end else if (w_at_max) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_gvalid && w_glast) begin
                  r_last_grant <= r_grant;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-port source queues, a logging
// FIFO sink, a vector table of single-packet cases and multi-packet sequences.
module tb_axis_pkt_arbiter;

   localparam int DW    = 32;
   localparam int NP    = 4;
   localparam int MB    = 16;
   localparam int DEPTH = 64;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int port;
      int nbeats;
      int base;
      int rmode;
      int exp_out;
      int exp_trunc;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NP*DW-1:0] s_data;
   logic [NP-1:0]    s_valid;
   logic [NP-1:0]    s_last;
   logic [NP-1:0]    s_ready;
   logic [DW-1:0]    writeData;
   logic             writeDataValid;
   logic             writeDataReady;
   logic             writeDataLast;
   logic             grant_valid;
   logic [1:0]       grant_idx;
   logic             trunc_err;

   always #5 clk = ~clk;

   axis_pkt_arbiter #(
      .DataWidth(DW),
      .NumPorts (NP),
      .MaxBeats (MB)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_last        (s_last),
      .s_ready       (s_ready),
      .writeData     (writeData),
      .writeDataValid(writeDataValid),
      .writeDataReady(writeDataReady),
      .writeDataLast (writeDataLast),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .trunc_err     (trunc_err)
   );

   beat_t       mem [NP][DEPTH];
   int          head [NP];
   int          tail [NP];
   logic [31:0] out_data [256];
   logic        out_last [256];
   int          out_port [256];
   int          out_cyc  [256];
   int          glog [16];
   int          n_out, n_g, n_trunc, trunc_at, trunc_nolast;
   int          viol, cyc, rmode, smp_gi;
   bit          prev_gv, smp_gv;
   int          n_chk = 0;
   int          n_err = 0;
   vec_t        vecs [6];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_q();
      for (int p = 0; p < NP; p++) begin
         head[p] = 0;
         tail[p] = 0;
      end
   endtask

   task automatic clear_log();
      n_out = 0;
      n_g = 0;
      n_trunc = 0;
      trunc_at = -1;
      prev_gv = 1'b0;
   endtask

   task automatic push(input int p, input int n, input int base);
      for (int b = 0; b < n; b++) begin
         if (tail[p] < DEPTH) begin
            mem[p][tail[p]].data = 32'(base + b);
            mem[p][tail[p]].last = (b == n - 1);
            tail[p]++;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         if (head[i] < tail[i]) begin
            s_valid[i]         = 1'b1;
            s_data[i*DW +: DW] = mem[i][head[i]].data;
            s_last[i]          = mem[i][head[i]].last;
         end else begin
            s_valid[i]         = 1'b0;
            s_data[i*DW +: DW] = $urandom;
            s_last[i]          = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // One clock: sample at negedge, advance sources after posedge.
   task automatic tick();
      logic [NP-1:0] pop;
      logic [NP-1:0] allowed;
      @(negedge clk);
      cyc++;
      smp_gv = grant_valid;
      smp_gi = int'(grant_idx);
      if (grant_valid && !prev_gv && n_g < 16) begin
         glog[n_g] = int'(grant_idx);
         n_g++;
      end
      prev_gv = grant_valid;
      allowed = grant_valid ? (NP'(1) << grant_idx) : '0;
      if ((s_ready & ~allowed) != '0) viol++;
      if (trunc_err) begin
         n_trunc++;
         trunc_at = n_out;
         if (!writeDataLast) trunc_nolast++;
      end
      if (writeDataValid && writeDataReady && n_out < 256) begin
         out_data[n_out] = writeData;
         out_last[n_out] = writeDataLast;
         out_port[n_out] = int'(grant_idx);
         out_cyc[n_out]  = cyc;
         n_out++;
      end
      pop = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) if (pop[i]) head[i]++;
      if (rmode == 1) writeDataReady = ~writeDataReady;
      drive();
   endtask

   task automatic run_until_idle(input string nm, input int budget);
      int  t;
      bit  done;
      t = 0;
      done = 1'b0;
      while (!done && t < budget) begin
         tick();
         t++;
         done = !smp_gv;
         for (int p = 0; p < NP; p++) if (head[p] != tail[p]) done = 1'b0;
      end
      chk({nm, "_done"}, int'(done), 1);
   endtask

   task automatic sb_check(input string nm);
      int bad;
      int k;
      bad = 0;
      for (int p = 0; p < NP; p++) begin
         k = 0;
         for (int o = 0; o < n_out; o++) begin
            if (out_port[o] == p) begin
               if (k >= tail[p]) bad++;
               else if (out_data[o] != mem[p][k].data ||
                        out_last[o] != mem[p][k].last) bad++;
               k++;
            end
         end
         if (k != tail[p]) bad++;
      end
      chk({nm, "_scoreboard"}, bad, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rmode = 0;
      writeDataReady = 1'b1;
      clear_q();
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_log();
   endtask

   initial begin
      int bad;
      int nl;
      int lpos;
      vecs[0] = '{2,  8, 32'hA0,  1,  8, 0};
      vecs[1] = '{1, 20, 32'h100, 0, 16, 1};
      vecs[2] = '{0, 16, 32'h200, 0, 16, 0};
      vecs[3] = '{3,  1, 32'h300, 0,  1, 0};
      vecs[4] = '{1, 17, 32'h400, 1, 16, 1};
      vecs[5] = '{2,  2, 32'h500, 1,  2, 0};

      cyc = 0;
      viol = 0;
      trunc_nolast = 0;
      rmode = 0;
      reset_n = 1'b0;
      writeDataReady = 1'b1;
      s_valid = '0;
      s_last = '0;
      s_data = '0;
      clear_q();
      clear_log();
      #12;
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_wvalid", int'(writeDataValid), 0);
      chk("rst_wlast", int'(writeDataLast), 0);
      chk("rst_gvalid", int'(grant_valid), 0);
      chk("rst_gidx", int'(grant_idx), 0);
      chk("rst_trunc", int'(trunc_err), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset in the middle of a packet
      push(2, 8, 32'h50);
      drive();
      tick();
      tick();
      tick();
      chk("midrst_pre_gvalid", int'(grant_valid), 1);
      chk("midrst_pre_ready", int'(s_ready), 4);
      reset_n = 1'b0;
      #1;
      chk("midrst_s_ready", int'(s_ready), 0);
      chk("midrst_wvalid", int'(writeDataValid), 0);
      chk("midrst_gvalid", int'(grant_valid), 0);
      clear_q();
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_log();
      push(0, 2, 32'h10);
      push(2, 2, 32'h20);
      drive();
      tick();
      chk("post_rst_idle", int'(smp_gv), 0);
      tick();
      chk("post_rst_gvalid", int'(smp_gv), 1);
      chk("post_rst_gidx", smp_gi, 0);
      run_until_idle("post_rst", 50);
      sb_check("post_rst");

      // Round-robin with continuous requests
      do_reset();
      for (int p = 0; p < NP; p++) push(p, 4, 32'h1000 + p * 32'h100);
      push(0, 4, 32'h1040);
      drive();
      run_until_idle("rr", 100);
      chk("rr_ngrants", n_g, 5);
      chk("rr_g0", glog[0], 0);
      chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 2);
      chk("rr_g3", glog[3], 3);
      chk("rr_g4", glog[4], 0);
      chk("rr_nout", n_out, 20);
      chk("rr_span", out_cyc[19] - out_cyc[3], 20);
      chk("rr_pkt_period", out_cyc[7] - out_cyc[3], 5);
      bad = 0;
      for (int k = 0; k < n_out; k++)
         if (out_last[k] != (k % 4 == 3)) bad++;
      chk("rr_last_pos", bad, 0);
      sb_check("rr");

      // Single-packet vectors
      for (int v = 0; v < 6; v++) begin
         do_reset();
         rmode = vecs[v].rmode;
         push(vecs[v].port, vecs[v].nbeats, vecs[v].base);
         drive();
         run_until_idle($sformatf("vec%0d", v), 200);
         rmode = 0;
         chk($sformatf("vec%0d_nout", v), n_out, vecs[v].exp_out);
         bad = 0;
         nl = 0;
         lpos = -1;
         for (int k = 0; k < n_out; k++) begin
            if (out_data[k] != 32'(vecs[v].base + k)) bad++;
            if (out_port[k] != vecs[v].port) bad++;
            if (out_last[k]) begin
               nl++;
               lpos = k;
            end
         end
         chk($sformatf("vec%0d_data", v), bad, 0);
         chk($sformatf("vec%0d_nlast", v), nl, 1);
         chk($sformatf("vec%0d_lastpos", v), lpos, vecs[v].exp_out - 1);
         chk($sformatf("vec%0d_trunc", v), n_trunc, vecs[v].exp_trunc);
         if (vecs[v].exp_trunc != 0)
            chk($sformatf("vec%0d_trunc_at", v), trunc_at, vecs[v].exp_out - 1);
      end

      // Truncation followed by the next requester
      do_reset();
      push(1, 20, 32'h700);
      push(2, 3, 32'h800);
      drive();
      run_until_idle("trunc", 200);
      chk("trunc_ngrants", n_g, 2);
      chk("trunc_g0", glog[0], 1);
      chk("trunc_g1", glog[1], 2);
      chk("trunc_nout", n_out, 19);
      chk("trunc_pulses", n_trunc, 1);
      chk("trunc_at", trunc_at, 15);
      bad = 0;
      for (int k = 0; k < n_out; k++) begin
         if (k < 16) begin
            if (out_data[k] != 32'(32'h700 + k) || out_port[k] != 1 ||
                out_last[k] != (k == 15)) bad++;
         end else begin
            if (out_data[k] != 32'(32'h800 + k - 16) || out_port[k] != 2 ||
                out_last[k] != (k == 18)) bad++;
         end
      end
      chk("trunc_data", bad, 0);

      // Isolation of a waiting port
      do_reset();
      push(0, 6, 32'h600);
      push(3, 3, 32'h630);
      drive();
      run_until_idle("iso", 100);
      chk("iso_ngrants", n_g, 2);
      chk("iso_g0", glog[0], 0);
      chk("iso_g1", glog[1], 3);
      chk("iso_nout", n_out, 9);
      sb_check("iso");

      chk("ready_isolation", viol, 0);
      chk("trunc_without_last", trunc_nolast, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
